// File: rtl/srv_bus_demux.sv
// srv_bus_demux
//   Steers upstream srv bus requests to one of MAX_REGION downstream slave
//   ports, selected by the address-hit decoder's one-hot vector. Responses
//   return in issue order. Only one target may have responses outstanding at
//   a time, so a request to a different target waits until they all drain.
//   A hit vector that is zero or has more than one bit set selects an
//   internal error target. That target accepts the request without
//   forwarding it and answers with err=1, rdata=0.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   us_req_vld/rdy                upstream request handshake
//   us_req_addr/wr/wdata/wstrb    upstream request fields
//   us_hit                        one-hot region hit for us_req_addr
//   us_rsp_vld/rdy                upstream response handshake
//   us_rsp_rdata/err              upstream response fields
//   ds_req_vld/rdy                per-port request handshake
//   ds_req_addr/wr/wdata/wstrb    shared request fields (copies of upstream)
//   ds_rsp_vld/rdy                per-port response handshake
//   ds_rsp_rdata                  per-port read data, port i at [32i+31:32i]
//   ds_rsp_err                    per-port response error
module srv_bus_demux #(
    parameter  int MAX_REGION = 2,
    parameter  int MAX_OUTST  = 4,
    localparam int CNT_W      = $clog2(MAX_OUTST + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     us_req_vld,
    output logic                     us_req_rdy,
    input  logic [31:0]              us_req_addr,
    input  logic                     us_req_wr,
    input  logic [31:0]              us_req_wdata,
    input  logic [3:0]               us_req_wstrb,
    input  logic [MAX_REGION-1:0]    us_hit,
    output logic                     us_rsp_vld,
    input  logic                     us_rsp_rdy,
    output logic [31:0]              us_rsp_rdata,
    output logic                     us_rsp_err,
    output logic [MAX_REGION-1:0]    ds_req_vld,
    input  logic [MAX_REGION-1:0]    ds_req_rdy,
    output logic [31:0]              ds_req_addr,
    output logic                     ds_req_wr,
    output logic [31:0]              ds_req_wdata,
    output logic [3:0]               ds_req_wstrb,
    input  logic [MAX_REGION-1:0]    ds_rsp_vld,
    output logic [MAX_REGION-1:0]    ds_rsp_rdy,
    input  logic [32*MAX_REGION-1:0] ds_rsp_rdata,
    input  logic [MAX_REGION-1:0]    ds_rsp_err
);

    // Target index MAX_REGION denotes the internal error responder.
    localparam int TGT_W = $clog2(MAX_REGION + 1);
    localparam logic [TGT_W-1:0] TGT_ERR = TGT_W'(MAX_REGION);

    logic [CNT_W-1:0] cnt;
    logic [TGT_W-1:0] tgt;
    logic [TGT_W-1:0] new_tgt;
    logic             hit_onehot;
    logic             can_issue;
    logic             sel_rdy;
    logic             cnt_zero;
    logic             req_hs;
    logic             rsp_hs;

    assign ds_req_addr  = us_req_addr;
    assign ds_req_wr    = us_req_wr;
    assign ds_req_wdata = us_req_wdata;
    assign ds_req_wstrb = us_req_wstrb;

    assign cnt_zero = (cnt == '0);

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
    assign hit_onehot = (us_hit != '0) && ((us_hit & (us_hit - 1'b1)) == '0);

    always_comb begin
        new_tgt = TGT_ERR;
        if (hit_onehot) begin
            for (int i = 0; i < MAX_REGION; i++) begin
                if (us_hit[i]) new_tgt = TGT_W'(i);
            end
        end
    end

    // The limit uses the registered count. A response that completes in the
    // same cycle does not free a slot until the next cycle.
    assign can_issue = cnt_zero ||
                       ((new_tgt == tgt) && (cnt < CNT_W'(MAX_OUTST)));

    // The error target is always ready. A port target follows its own ready.
    always_comb begin
        sel_rdy = (new_tgt == TGT_ERR);
        for (int i = 0; i < MAX_REGION; i++) begin
            if (new_tgt == TGT_W'(i)) sel_rdy = ds_req_rdy[i];
        end
    end

    // The request path is combinational. During reset it is forced idle.
    always_comb begin
        ds_req_vld = '0;
        for (int i = 0; i < MAX_REGION; i++) begin
            ds_req_vld[i] = rst_n & us_req_vld & can_issue & (new_tgt == TGT_W'(i));
        end
    end

    assign us_req_rdy = rst_n & can_issue & sel_rdy;

    // Only the current target is routed. Stray responses from other ports
    // see rdy=0 and remain pending at their port.
    always_comb begin
        us_rsp_vld   = 1'b0;
        us_rsp_rdata = '0;
        us_rsp_err   = 1'b0;
        ds_rsp_rdy   = '0;
        if (!cnt_zero) begin
            if (tgt == TGT_ERR) begin
                us_rsp_vld = 1'b1;
                us_rsp_err = 1'b1;
            end else begin
                for (int i = 0; i < MAX_REGION; i++) begin
                    if (tgt == TGT_W'(i)) begin
                        us_rsp_vld    = ds_rsp_vld[i];
                        us_rsp_rdata  = ds_rsp_rdata[32*i +: 32];
                        us_rsp_err    = ds_rsp_err[i];
                        ds_rsp_rdy[i] = us_rsp_rdy;
                    end
                end
            end
        end
    end

    assign req_hs = us_req_vld & us_req_rdy;
    assign rsp_hs = us_rsp_vld & us_rsp_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tgt <= '0;
        end else begin
            if (req_hs) tgt <= new_tgt;
            case ({req_hs, rsp_hs})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_srv_bus_demux.sv
module tb_srv_bus_demux;

    localparam int NR  = 2;
    localparam int MO  = 4;
    localparam int ERR = NR;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            us_req_vld = 1'b0;
    logic            us_req_rdy;
    logic [31:0]     us_req_addr = '0;
    logic            us_req_wr = 1'b0;
    logic [31:0]     us_req_wdata = '0;
    logic [3:0]      us_req_wstrb = '0;
    logic [NR-1:0]   us_hit = '0;
    logic            us_rsp_vld;
    logic            us_rsp_rdy = 1'b0;
    logic [31:0]     us_rsp_rdata;
    logic            us_rsp_err;
    logic [NR-1:0]   ds_req_vld;
    logic [NR-1:0]   ds_req_rdy = '0;
    logic [31:0]     ds_req_addr;
    logic            ds_req_wr;
    logic [31:0]     ds_req_wdata;
    logic [3:0]      ds_req_wstrb;
    logic [NR-1:0]   ds_rsp_vld = '0;
    logic [NR-1:0]   ds_rsp_rdy;
    logic [32*NR-1:0] ds_rsp_rdata = '0;
    logic [NR-1:0]   ds_rsp_err = '0;

    int vectors = 0;
    int miscompares = 0;

    // Model: targets of accepted, unanswered requests in issue order.
    int q[$];

    srv_bus_demux #(.MAX_REGION(NR), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .us_req_vld(us_req_vld), .us_req_rdy(us_req_rdy),
        .us_req_addr(us_req_addr), .us_req_wr(us_req_wr),
        .us_req_wdata(us_req_wdata), .us_req_wstrb(us_req_wstrb),
        .us_hit(us_hit),
        .us_rsp_vld(us_rsp_vld), .us_rsp_rdy(us_rsp_rdy),
        .us_rsp_rdata(us_rsp_rdata), .us_rsp_err(us_rsp_err),
        .ds_req_vld(ds_req_vld), .ds_req_rdy(ds_req_rdy),
        .ds_req_addr(ds_req_addr), .ds_req_wr(ds_req_wr),
        .ds_req_wdata(ds_req_wdata), .ds_req_wstrb(ds_req_wstrb),
        .ds_rsp_vld(ds_rsp_vld), .ds_rsp_rdy(ds_rsp_rdy),
        .ds_rsp_rdata(ds_rsp_rdata), .ds_rsp_err(ds_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Settle the inputs, compare every output against the model, then
    // advance the model by the handshakes the model says occur this cycle.
    task automatic eval();
        int nt;
        bit ok;
        logic [NR-1:0] e_dsv, e_dsr;
        logic e_rdy, e_vld, e_err;
        logic [31:0] e_rdata;
        #1;
        nt = ERR;
        if ($countones(us_hit) == 1)
            for (int i = 0; i < NR; i++) if (us_hit[i]) nt = i;
        e_dsv = '0; e_dsr = '0; e_rdy = 0; e_vld = 0; e_err = 0; e_rdata = '0;
        if (!rst_n) begin
            q.delete();
        end else begin
            ok = (q.size() == 0) || (nt == q[0] && q.size() < MO);
            if (us_req_vld && ok && nt != ERR) e_dsv[nt] = 1'b1;
            e_rdy = ok && ((nt == ERR) || ds_req_rdy[nt]);
            if (q.size() != 0) begin
                if (q[0] == ERR) begin
                    e_vld = 1; e_err = 1;
                end else begin
                    e_vld   = ds_rsp_vld[q[0]];
                    e_rdata = ds_rsp_rdata[32*q[0] +: 32];
                    e_err   = ds_rsp_err[q[0]];
                    e_dsr[q[0]] = us_rsp_rdy;
                end
            end
            chk("ds_req_addr", ds_req_addr, us_req_addr);
            chk("ds_req_wfields", {ds_req_wr, ds_req_wstrb, ds_req_wdata},
                {us_req_wr, us_req_wstrb, us_req_wdata});
        end
        chk("ds_req_vld", ds_req_vld, e_dsv);
        chk("us_req_rdy", us_req_rdy, e_rdy);
        chk("us_rsp_vld", us_rsp_vld, e_vld);
        chk("us_rsp_rdata", us_rsp_rdata, e_rdata);
        chk("us_rsp_err", us_rsp_err, e_err);
        chk("ds_rsp_rdy", ds_rsp_rdy, e_dsr);
        if (rst_n) begin
            if (e_vld && us_rsp_rdy) void'(q.pop_front());
            if (us_req_vld && e_rdy) q.push_back(nt);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        us_req_vld = 0; ds_rsp_vld = '0; us_rsp_rdy = 0; ds_req_rdy = '1;
    endtask

    task automatic drain();
        us_req_vld = 0; ds_rsp_vld = '1; us_rsp_rdy = 1;
        repeat (MO + 2) begin eval(); adv(); end
        chk("drain_empty", q.size(), 0);
        set_idle();
    endtask

    initial begin
        logic [1:0] bad_hits [2];
        int r;
        bad_hits[0] = 2'b00;
        bad_hits[1] = 2'b11;

        // Reset values
        us_req_vld = 1; us_hit = 2'b01; ds_req_rdy = '1;
        eval();
        chk("rst_req_rdy", us_req_rdy, 0);
        chk("rst_ds_req_vld", ds_req_vld, 0);
        adv();
        rst_n = 1;
        set_idle();
        eval(); adv();

        // Single read to port0, response two cycles later
        us_req_vld = 1; us_hit = 2'b01; us_req_addr = 32'h5000_0010; ds_req_rdy = 2'b01;
        eval();
        chk("single_dsv", ds_req_vld, 2'b01);
        chk("single_rdy", us_req_rdy, 1);
        adv();
        us_req_vld = 0; eval(); adv();
        ds_rsp_vld = 2'b01; ds_rsp_rdata = {32'h0, 32'hA5A5_0001}; ds_rsp_err = '0; us_rsp_rdy = 1;
        eval();
        chk("single_rsp_vld", us_rsp_vld, 1);
        chk("single_rsp_rdata", us_rsp_rdata, 32'hA5A5_0001);
        chk("single_rsp_err", us_rsp_err, 0);
        adv();
        ds_rsp_vld = 2'b01;
        eval();
        chk("single_cnt0_vld", us_rsp_vld, 0);
        adv();
        set_idle();

        // Four outstanding to port1, fifth stalls
        us_req_vld = 1; us_hit = 2'b10;
        repeat (4) begin eval(); chk("b2b_rdy", us_req_rdy, 1); adv(); end
        eval();
        chk("b2b_5th_stall", us_req_rdy, 0);
        adv();
        ds_rsp_vld = 2'b10; ds_rsp_rdata = {32'hB0B0_0001, 32'h0}; us_rsp_rdy = 1;
        eval();
        chk("b2b_same_cycle_stall", us_req_rdy, 0);
        chk("b2b_rsp_vld", us_rsp_vld, 1);
        adv();
        ds_rsp_rdata = {32'hB0B0_0002, 32'h0};
        eval();
        chk("b2b_5th_issue", us_req_rdy, 1);
        adv();
        drain();

        // Target switch waits for port0 to drain
        us_req_vld = 1; us_hit = 2'b01;
        repeat (2) begin eval(); adv(); end
        us_hit = 2'b10;
        eval();
        chk("switch_dsv_hold", ds_req_vld, 2'b00);
        chk("switch_rdy_hold", us_req_rdy, 0);
        adv();
        ds_rsp_vld = 2'b01; us_rsp_rdy = 1;
        repeat (2) begin eval(); chk("switch_dsv_drain", ds_req_vld, 2'b00); adv(); end
        eval();
        chk("switch_dsv_go", ds_req_vld, 2'b10);
        chk("switch_rdy_go", us_req_rdy, 1);
        adv();
        drain();

        // Decode errors
        for (int k = 0; k < 2; k++) begin
            us_req_vld = 1; us_hit = bad_hits[k];
            eval();
            chk("decerr_dsv", ds_req_vld, 2'b00);
            chk("decerr_rdy", us_req_rdy, 1);
            adv();
            us_req_vld = 0; us_rsp_rdy = 1;
            eval();
            chk("decerr_rsp_vld", us_rsp_vld, 1);
            chk("decerr_rsp_err", us_rsp_err, 1);
            chk("decerr_rsp_rdata", us_rsp_rdata, 0);
            adv();
            set_idle();
        end

        // Backpressure with stray port1 response
        us_req_vld = 1; us_hit = 2'b01;
        eval(); adv();
        us_req_vld = 0; ds_rsp_vld = 2'b11;
        ds_rsp_rdata = {32'h2222_2222, 32'h1111_1111}; ds_rsp_err = 2'b10; us_rsp_rdy = 0;
        repeat (3) begin
            eval();
            chk("bp_vld", us_rsp_vld, 1);
            chk("bp_rdata", us_rsp_rdata, 32'h1111_1111);
            chk("bp_ds_rsp_rdy", ds_rsp_rdy, 2'b00);
            adv();
        end
        us_rsp_rdy = 1;
        eval();
        chk("bp_release_rdy", ds_rsp_rdy, 2'b01);
        adv();
        eval();
        chk("bp_stray_not_fwd", us_rsp_vld, 0);
        chk("bp_stray_rdy", ds_rsp_rdy, 2'b00);
        adv();
        set_idle(); ds_rsp_err = '0;

        // Async reset with three outstanding
        us_req_vld = 1; us_hit = 2'b10;
        repeat (3) begin eval(); adv(); end
        us_req_vld = 0; ds_rsp_vld = 2'b10;
        eval();
        chk("arst_pre_vld", us_rsp_vld, 1);
        rst_n = 0;
        eval();
        chk("arst_rsp_vld", us_rsp_vld, 0);
        chk("arst_req_rdy", us_req_rdy, 0);
        adv();
        rst_n = 1; ds_rsp_vld = '0; us_req_vld = 1; us_hit = 2'b10;
        eval();
        chk("arst_after_dsv", ds_req_vld, 2'b10);
        chk("arst_after_rdy", us_req_rdy, 1);
        adv();
        drain();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            us_req_vld = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            us_hit = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            us_req_addr = $urandom; us_req_wdata = $urandom;
            us_req_wr = $urandom_range(0, 1); us_req_wstrb = 4'($urandom);
            ds_req_rdy = 2'($urandom);
            ds_rsp_vld = 2'($urandom);
            ds_rsp_rdata = {$urandom, $urandom};
            ds_rsp_err = 2'($urandom);
            us_rsp_rdy = ($urandom_range(0, 3) != 0);
            eval();
            adv();
        end
        rst_n = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
